// File: rtl/rom_stream_reader.sv
// -----------------------------------------------------------------------------
// rom_stream_reader
//
// Reads a burst of consecutive words from a synchronous ROM and presents them
// as a ready/valid stream. A burst is requested with start/start_addr/length
// while idle. Reads are issued one per cycle as long as the two-entry output
// buffer, counting the read still in flight, has room. This lets a stream with
// out_ready held high run at one beat per cycle without ever overflowing.
//
// Ports
//   clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   burst request, sampled only while idle
//   start_addr  in   first ROM word address of the burst
//   length      in   number of words in the burst (0 = empty burst)
//   busy        out  burst in progress (RUN or FINISH)
//   done        out  one-cycle completion pulse (FINISH)
//   rom_addr    out  registered ROM address
//   rom_data    in   ROM read data, valid one edge after rom_addr
//   out_data    out  stream data (buffer head)
//   out_valid   out  stream data valid
//   out_ready   in   downstream ready
//   out_last    out  final beat of the burst
// -----------------------------------------------------------------------------
module rom_stream_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH-1:0] length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [ADDRESS_WIDTH-1:0] rom_addr_q, rom_addr_d;
  // Words still to be requested from the ROM.
  logic [ADDRESS_WIDTH-1:0] issue_left_q, issue_left_d;
  // Beats still to be delivered downstream; out_last when this reaches 1.
  logic [ADDRESS_WIDTH-1:0] beats_left_q, beats_left_d;
  // A read was issued at the last edge; its data is on rom_data now.
  logic                     inflight_q, inflight_d;

  // Two-entry output FIFO.
  logic [DATA_WIDTH-1:0]    mem_q [2];
  logic [DATA_WIDTH-1:0]    mem_d [2];
  logic                     rd_ptr_q, rd_ptr_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic [1:0]               count_q, count_d;

  logic                     push;
  logic                     pop;
  logic                     issue;
  logic [2:0]               occ;
  logic [2:0]               occ_after_pop;

  // Stream outputs come straight from registered state.
  assign out_valid = (state_q == ST_RUN) && (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_last  = out_valid && (beats_left_q == ADDRESS_WIDTH'(1));
  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_addr  = rom_addr_q;

  assign pop  = out_valid && out_ready;
  // Only a read we issued ourselves is captured, so data presented by the ROM
  // after a reset never lands in the buffer.
  assign push = inflight_q;

  // Occupancy includes the in-flight read so the buffer can never overflow;
  // a pop this cycle frees a slot early, which is what keeps the stream
  // gap-free at full rate.
  assign occ           = {1'b0, count_q} + {2'b00, inflight_q};
  assign occ_after_pop = occ - {2'b00, pop};
  assign issue         = (state_q == ST_RUN) &&
                         (issue_left_q != '0) &&
                         (occ_after_pop < 3'd2);

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    issue_left_d = issue_left_q;
    beats_left_d = beats_left_q;
    inflight_d   = issue;
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d      = ST_RUN;
            rom_addr_d   = start_addr;
            issue_left_d = length;
            beats_left_d = length;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_RUN: begin
        if (pop && out_last) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Address wraps naturally modulo 2^ADDRESS_WIDTH.
    if (issue) begin
      rom_addr_d   = rom_addr_q + ADDRESS_WIDTH'(1);
      issue_left_d = issue_left_q - ADDRESS_WIDTH'(1);
    end

    if (pop) begin
      beats_left_d = beats_left_q - ADDRESS_WIDTH'(1);
      rd_ptr_d     = ~rd_ptr_q;
    end

    if (push) begin
      mem_d[wr_ptr_q] = rom_data;
      wr_ptr_d        = ~wr_ptr_q;
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // busy/done are registered from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rom_addr_q   <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rom_addr_q   <= rom_addr_d;
      issue_left_q <= issue_left_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= inflight_d;
      mem_q[0]     <= mem_d[0];
      mem_q[1]     <= mem_d[1];
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_stream_reader
//
// Directed bench for rom_stream_reader with a synchronous ROM model whose
// word[a] = 0xA500_0000 | a. Bursts come from a vector table; empty burst
// and reset mid-burst are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_rom_stream_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] start_addr;
  logic [11:0] length;
  logic        busy;
  logic        done;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int errors;
  int checks;

  rom_stream_reader #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(12)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data for the address seen at an edge appears after it.
  always @(posedge clk) rom_data <= 32'hA500_0000 | {20'h0, rom_addr};

  typedef struct {
    logic [11:0] addr;
    logic [11:0] len;
    int          mode;     // 0: ready always high, 1: toggle then stall
    bit          restart;  // pulse start with addr 0x100 mid-burst
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [11:0] exp_end_addr;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v, input bit rel_rst);
    int          idx;
    int          cyc;
    bit          fin;
    bit          prev_stall;
    logic [31:0] exp;
    logic [11:0] diff;
    @(negedge clk);
    start      = 1'b1;
    start_addr = v.addr;
    length     = v.len;
    out_ready  = (v.mode == 0);
    if (rel_rst) reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    start_addr = 12'h0;
    length     = 12'h0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("rom_addr_load", {20'h0, rom_addr}, {20'h0, v.addr});
    check("done_low_in_run", {31'b0, done}, 32'd0);
    idx = 0;
    cyc = 0;
    fin = 1'b0;
    prev_stall = 1'b0;
    while (!fin && cyc < 200) begin
      if (cyc != 0) @(negedge clk);
      if (v.restart && cyc == 3) begin
        start      = 1'b1;
        start_addr = 12'h100;
        length     = 12'd7;
      end else begin
        start      = 1'b0;
        start_addr = 12'h0;
        length     = 12'h0;
      end
      diff = rom_addr - v.addr - idx[11:0];
      check("addr_ahead_le2", {31'b0, (diff <= 12'd2)}, 32'd1);
      if (prev_stall) check("stall_valid_hold", {31'b0, out_valid}, 32'd1);
      if (cyc < 2) check("no_early_valid", {31'b0, out_valid}, 32'd0);
      if (out_valid) begin
        exp = 32'hA500_0000 | {20'h0, v.addr + idx[11:0]};
        check("beat_data", out_data, exp);
        check("beat_last", {31'b0, out_last}, {31'b0, (idx == int'(v.len) - 1)});
        if (idx == 0) check("first_beat", out_data, v.exp_first);
        if (idx == int'(v.len) - 1) check("last_beat", out_data, v.exp_last);
        if (v.mode == 0) check("beat_cycle", cyc, 2 + idx);
      end
      if (v.mode == 0) out_ready = 1'b1;
      else if (cyc < 12) out_ready = (cyc % 2 == 1);
      else if (cyc < 17) out_ready = 1'b0;
      else out_ready = 1'b1;
      prev_stall = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        idx++;
        if (idx == int'(v.len)) fin = 1'b1;
      end
      cyc++;
    end
    if (!fin) check("burst_timeout", 32'd0, 32'd1);
    @(negedge clk);
    start      = 1'b0;
    start_addr = 12'h0;
    length     = 12'h0;
    check("done_pulse", {31'b0, done}, 32'd1);
    check("busy_in_finish", {31'b0, busy}, 32'd1);
    check("no_valid_in_finish", {31'b0, out_valid}, 32'd0);
    check("end_addr", {20'h0, rom_addr}, {20'h0, v.exp_end_addr});
    @(negedge clk);
    check("done_cleared", {31'b0, done}, 32'd0);
    check("busy_cleared", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    vec_t r;
    int   acc;
    errors     = 0;
    checks     = 0;
    reset_n    = 1'b1;
    start      = 1'b0;
    start_addr = 12'h0;
    length     = 12'h0;
    out_ready  = 1'b0;

    vecs[0] = '{12'h010, 12'd4, 0, 1'b0, 32'hA500_0010, 32'hA500_0013, 12'h014};
    vecs[1] = '{12'hFFE, 12'd4, 0, 1'b0, 32'hA500_0FFE, 32'hA500_0001, 12'h002};
    vecs[2] = '{12'h300, 12'd8, 1, 1'b0, 32'hA500_0300, 32'hA500_0307, 12'h308};
    vecs[3] = '{12'h050, 12'd5, 0, 1'b1, 32'hA500_0050, 32'hA500_0054, 12'h055};

    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_last", {31'b0, out_last}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_rom_addr", {20'h0, rom_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);

    // First vector releases reset together with start.
    for (int i = 0; i < 4; i++) run_burst(vecs[i], (i == 0));

    // Empty burst: one cycle busy, one done pulse, no beats.
    @(negedge clk);
    out_ready  = 1'b1;
    start      = 1'b1;
    start_addr = 12'h200;
    length     = 12'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", {31'b0, busy}, 32'd1);
    check("len0_done", {31'b0, done}, 32'd1);
    check("len0_valid", {31'b0, out_valid}, 32'd0);
    check("len0_rom_addr", {20'h0, rom_addr}, 32'h055);
    @(negedge clk);
    check("len0_busy_end", {31'b0, busy}, 32'd0);
    check("len0_done_end", {31'b0, done}, 32'd0);
    check("len0_valid_end", {31'b0, out_valid}, 32'd0);
    check("len0_rom_addr_hold", {20'h0, rom_addr}, 32'h055);

    // Reset after the third beat of a length-6 burst.
    @(negedge clk);
    start      = 1'b1;
    start_addr = 12'h040;
    length     = 12'd6;
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc   = 0;
    for (int k = 0; k < 50 && acc < 3; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) acc++;
    end
    check("rstseq_three_beats", acc, 32'd3);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_last", {31'b0, out_last}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_rom_addr", {20'h0, rom_addr}, 32'd0);
    @(negedge clk);
    check("mid_rst_no_done", {31'b0, done}, 32'd0);
    r = '{12'h020, 12'd2, 0, 1'b0, 32'hA500_0020, 32'hA500_0021, 12'h022};
    run_burst(r, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rom_stream_reader.md
ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of ROM words and stream data.
REQ-002 Parameter ADDRESS_WIDTH, default 12, width of ROM address and of length.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a burst; sampled only in IDLE.
REQ-006 start_addr  input  ADDRESS_WIDTH  first ROM word address of burst.
REQ-007 length  input  ADDRESS_WIDTH  number of words in burst; 0 = empty burst.
REQ-008 busy  output  1  high while a burst is in progress.
REQ-009 done  output  1  one-cycle pulse at burst completion.
REQ-010 rom_addr  output  ADDRESS_WIDTH  address to ROM; registered.
REQ-011 rom_data  input  DATA_WIDTH  ROM read data, valid one edge after rom_addr is presented.
REQ-012 out_data  output  DATA_WIDTH  stream data, from head of internal buffer.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts; beat transfers when out_valid and out_ready both high at an edge.
REQ-015 out_last  output  1  high with the final beat of a burst.

Function
REQ-016 FSM states: IDLE, RUN, FINISH; IDLE->RUN on start with length!=0; IDLE->FINISH on start with length==0; RUN->FINISH at edge transferring beat with out_last; FINISH->IDLE unconditionally after one cycle.
REQ-017 done high only in FINISH; busy high in RUN and FINISH.
REQ-018 start while busy ignored; start_addr and length captured only at the accepting edge.
REQ-019 Read issue: in RUN, a read issues in a cycle when words-left-to-issue>0 and (buffer occupancy + in-flight read − pop this cycle) < 2; rom_addr then advances by 1 at the edge.
REQ-020 Address arithmetic modulo 2^ADDRESS_WIDTH; address max wraps to 0 within a burst.
REQ-021 Latency: start sampled at edge N -> rom_addr=start_addr after edge N; first out_valid high after edge N+2.
REQ-022 In-flight flag set at issue edge; rom_data written into buffer at following edge; flag cleared unless new issue.
REQ-023 Buffer: 2-entry FIFO; never overflows; simultaneous push and pop at depth 2 or 1 allowed, occupancy unchanged.
REQ-024 out_data/out_valid/out_last held stable while out_valid high and out_ready low.
REQ-025 out_ready held high -> one beat per cycle, no bubbles after the first beat.
REQ-026 out_last asserted exactly on beat number length (counted from 1); beats delivered in address order.
REQ-027 out_ready is ignored while out_valid low; no beat is emitted outside RUN.
REQ-028 rom_addr holds its value in IDLE and FINISH.

Reset
REQ-029 reset_n low immediately forces: state IDLE, busy 0, done 0, out_valid 0, out_last 0, out_data 0, rom_addr 0, buffer empty, in-flight cleared, counters 0.
REQ-030 Reset mid-burst abandons the burst; no done pulse; stale rom_data arriving after reset release never enters the buffer.
REQ-031 First start after reset release is accepted at the first rising edge with reset_n high.

Verification (bench ROM: word[a] = 0xA500_0000 | a)
REQ-032 start_addr=0x010, length=4, out_ready=1 -> beats 0xA5000010..0xA5000013 on 4 consecutive cycles, first after edge N+2, out_last on 4th, done one cycle after 4th beat.
REQ-033 start_addr=0xFFE, length=4 -> beats 0xA5000FFE, 0xA5000FFF, 0xA5000000, 0xA5000001.
REQ-034 length=8, out_ready toggled 1/0 each cycle then held low 5 cycles -> all 8 words in order, no loss/duplication, outputs stable while stalled, rom_addr never more than 2 ahead of accepted beats.
REQ-035 length=0 -> busy high 1 cycle, done one pulse, out_valid never asserted.
REQ-036 start pulsed again during a burst with start_addr=0x100 -> ignored; current burst completes unchanged.
REQ-037 reset_n low after 3rd beat of a length-6 burst -> all outputs reset immediately; new burst start_addr=0x020, length=2 -> exactly 0xA5000020, 0xA5000021.
